prog_mealy_fsm: RTL and testbench
=================================

// Module: prog_mealy_fsm
// PURPOSE
//   Table-driven, runtime-programmable Mealy/Moore state machine engine.
//   Replaces the hand-coded 4-state, 2-input controllers: next state and Mealy output come from a
//   writable transition table indexed by {state, x}.
//   Also provides a transition counter, a match-state pulse and a selectable registered Mealy output.
//   Sits between the input synchroniser and the downstream control decode.
// PARAMETERS
//   IN_W     2   width of input vector x
//   ST_W     2   state register width; NUM_ST = 2**ST_W states
//   OUT_W    1   width of Mealy output z_mealy
//   CNT_W    8   width of transition counter trans_cnt
//   INIT_ST  0   state entered on reset and on sync_clr
//   MATCH_ST 3   state whose entry raises hit
//   REG_OUT  0   0: z_mealy combinational from table; 1: z_mealy registered (+1 cycle)
// PORTS
//   clk        in   1              clock, rising edge
//   reset      in   1              asynchronous, active-high reset
//   run        in   1              1: FSM advances each clk; 0: FSM holds, config allowed
//   sync_clr   in   1              synchronous return to INIT_ST, clears trans_cnt
//   x          in   IN_W           FSM input vector
//   cfg_we     in   1              table write strobe
//   cfg_addr   in   ST_W+IN_W      table index {state, x}
//   cfg_wdata  in   ST_W+OUT_W     entry {next_state, mealy_out}
//   cfg_rdata  out  ST_W+OUT_W     registered read of entry at cfg_addr
//   cfg_err    out  1              1-cycle pulse: write attempted while run=1
//   state      out  ST_W           current state (Moore output)
//   z_mealy    out  OUT_W          Mealy output
//   hit        out  1              1-cycle pulse on entry into MATCH_ST
//   trans_cnt  out  CNT_W          count of state changes, saturating
// BEHAVIOUR
//   Reset (async, immediate, also mid-operation):
//     state=INIT_ST; trans_cnt=0; hit=0; cfg_err=0; cfg_rdata=0; registered z_mealy=0.
//     Every table entry i = {next=i[ST_W+IN_W-1:IN_W] (self-loop), out=0}.
//   Table: DEPTH = 2**(ST_W+IN_W) entries; entry e = tbl[{state,x}].
//   Per clk, priority order:
//     1. sync_clr=1: state<=INIT_ST; trans_cnt<=0; hit<=0. Overrides run.
//     2. run=1: state<=e.next. If e.next!=state, trans_cnt<=trans_cnt+1, saturating at all-ones.
//        hit<=1 iff e.next==MATCH_ST and state!=MATCH_ST; otherwise hit<=0.
//     3. run=0: state and trans_cnt hold; hit<=0.
//   z_mealy:
//     REG_OUT=0: z_mealy = run ? e.out : 0, combinational, same cycle as x.
//     REG_OUT=1: z_mealy <= run ? e.out : 0, updated on the same edge as state; 0 on sync_clr.
//   Config:
//     cfg_we=1 with run=0: tbl[cfg_addr]<=cfg_wdata; the entry is used from the next cycle.
//     cfg_we=1 with run=1: write dropped, cfg_err<=1 for one cycle. No table hazard in run mode.
//     cfg_rdata <= tbl[cfg_addr] every cycle (1-cycle latency). Read of the address being written
//       returns the old value.
//     next_state field values >= NUM_ST cannot occur: the field is exactly ST_W wide.
//   Simultaneous events:
//     sync_clr with cfg_we (run=0): both take effect.
//     Counter saturation does not block state updates or hit.
// TESTING (defaults; A..D = 0..3, addr = {state,x})
//   1. Reset, then run=1, x=2'b11 for 4 clk -> state stays 0, trans_cnt=0, z_mealy=0, hit never 1.
//   2. run=0, load table:
//        A:11->{D,1}, else {A,0}
//        B:00/01->{A,0}, 11->{B,0}, 10->{B,1}
//        C:10->{B,1}, else {C,0}
//        D:00/01->{C,0}, 11->{D,1}, 10->{A,0}
//      Read back all 16 entries -> cfg_rdata matches, 1 cycle after the address is applied.
//   3. From A, run=1, x=11,11,00,10
//        -> state D,D,C,B; z_mealy 1,1,0,1 (REG_OUT=0); trans_cnt=3; hit exactly once, after the first edge.
//   4. cfg_we=1 with run=1 -> cfg_err pulses 1 cycle, cfg_rdata of that entry unchanged.
//      sync_clr mid-run -> state=0, trans_cnt=0.
//   5. REG_OUT=1 build, repeat scenario 3 -> z_mealy is the REG_OUT=0 sequence delayed 1 clk.
//      CNT_W=2 with toggling table -> trans_cnt saturates at 3.
//   6. Assert reset between edges during scenario 3 -> all outputs go to reset values
//      immediately and the table reverts to self-loops.

Source files
------------

// File: rtl/prog_mealy_fsm.sv
// Table-driven Mealy/Moore state machine: next state and Mealy output come from a
// runtime-writable table indexed by {state, x}, plus a transition counter and a match pulse.
module prog_mealy_fsm #(
    parameter int unsigned IN_W     = 2,
    parameter int unsigned ST_W     = 2,
    parameter int unsigned OUT_W    = 1,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned INIT_ST  = 0,
    parameter int unsigned MATCH_ST = 3,
    parameter int unsigned REG_OUT  = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    sync_clr,
    input  logic [IN_W-1:0]         x,
    input  logic                    cfg_we,
    input  logic [ST_W+IN_W-1:0]    cfg_addr,
    input  logic [ST_W+OUT_W-1:0]   cfg_wdata,
    output logic [ST_W+OUT_W-1:0]   cfg_rdata,
    output logic                    cfg_err,
    output logic [ST_W-1:0]         state,
    output logic [OUT_W-1:0]        z_mealy,
    output logic                    hit,
    output logic [CNT_W-1:0]        trans_cnt
);

    localparam int unsigned AW    = ST_W + IN_W;
    localparam int unsigned DW    = ST_W + OUT_W;
    localparam int unsigned DEPTH = 2 ** AW;

    localparam logic [ST_W-1:0] INIT_S  = ST_W'(INIT_ST);
    localparam logic [ST_W-1:0] MATCH_S = ST_W'(MATCH_ST);

    logic [DW-1:0]    tbl [DEPTH];
    logic [AW-1:0]    idx;
    logic [DW-1:0]    entry;
    logic [ST_W-1:0]  nxt_st;
    logic [OUT_W-1:0] ent_out;
    logic [OUT_W-1:0] z_reg;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign idx     = {state, x};
    assign entry   = tbl[idx];
    assign nxt_st  = entry[DW-1:OUT_W];
    assign ent_out = entry[OUT_W-1:0];

    // Table lives in flops so reset can restore the self-loop image in one step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= {ST_W'(i >> IN_W), {OUT_W{1'b0}}};
            end
            cfg_rdata <= '0;
            cfg_err   <= 1'b0;
        end else begin
            if (cfg_we && !run) begin
                tbl[cfg_addr] <= cfg_wdata;
            end
            cfg_rdata <= tbl[cfg_addr];
            cfg_err   <= cfg_we && run;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= INIT_S;
            trans_cnt <= '0;
            hit       <= 1'b0;
            z_reg     <= '0;
        end else if (sync_clr) begin
            state     <= INIT_S;
            trans_cnt <= '0;
            hit       <= 1'b0;
            z_reg     <= '0;
        end else if (run) begin
            state <= nxt_st;
            if (nxt_st != state) begin
                trans_cnt <= sat_inc(trans_cnt);
            end
            hit   <= (nxt_st == MATCH_S) && (state != MATCH_S);
            z_reg <= ent_out;
        end else begin
            hit   <= 1'b0;
            z_reg <= '0;
        end
    end

    assign z_mealy = (REG_OUT != 0) ? z_reg : (run ? ent_out : '0);

endmodule

// File: tb/tb_prog_mealy_fsm.sv
// Scoreboard bench for prog_mealy_fsm: one default instance and one REG_OUT=1, CNT_W=2
// instance share the same stimulus.
module tb_prog_mealy_fsm;

    logic       clk = 1'b0;
    logic       reset, run, sync_clr, cfg_we;
    logic [1:0] x;
    logic [3:0] cfg_addr;
    logic [2:0] cfg_wdata;

    logic [2:0] rdata0, rdata1;
    logic       err0, err1, z0, z1, hit0, hit1;
    logic [1:0] st0, st1;
    logic [7:0] cnt0;
    logic [1:0] cnt1;

    prog_mealy_fsm dut0 (
        .clk(clk), .reset(reset), .run(run), .sync_clr(sync_clr), .x(x),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_rdata(rdata0), .cfg_err(err0), .state(st0), .z_mealy(z0),
        .hit(hit0), .trans_cnt(cnt0)
    );

    prog_mealy_fsm #(.REG_OUT(1), .CNT_W(2)) dut1 (
        .clk(clk), .reset(reset), .run(run), .sync_clr(sync_clr), .x(x),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_rdata(rdata1), .cfg_err(err1), .state(st1), .z_mealy(z1),
        .hit(hit1), .trans_cnt(cnt1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] rdata;
        logic       err;
        logic [1:0] st;
        logic       hit;
        logic       z_reg;
        logic [7:0] cnt;
        logic [1:0] cnt2;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_err    = 0;
    logic [2:0] m_tbl [16];
    logic [1:0] m_st;
    int         m_cnt, m_cnt2, hit_seen;
    logic       z_pre;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_st   = 2'd0;
        m_cnt  = 0;
        m_cnt2 = 0;
        for (int i = 0; i < 16; i++) m_tbl[i] = 3'((i >> 2) << 1);
    endtask

    // Reference programming image for scenario 2: {next_state, out} per {state, x}.
    function automatic logic [2:0] prog_entry(input int a);
        int s = a >> 2;
        int xx = a & 3;
        case (s)
            0:       return (xx == 3) ? 3'b111 : 3'b000;
            1:       return (xx < 2) ? 3'b000 : (xx == 3) ? 3'b010 : 3'b011;
            2:       return (xx == 2) ? 3'b011 : 3'b100;
            default: return (xx < 2) ? 3'b100 : (xx == 3) ? 3'b111 : 3'b000;
        endcase
    endfunction

    task automatic cycle();
        exp_t       e;
        logic [2:0] ent;
        logic [1:0] nxt;
        @(negedge clk);
        ent   = m_tbl[{m_st, x}];
        nxt   = ent[2:1];
        z_pre = z0;
        check("z_comb", z0, run ? ent[0] : 1'b0);
        e.rdata = m_tbl[cfg_addr];
        e.err   = cfg_we && run;
        if (sync_clr) begin
            m_st = 2'd0; m_cnt = 0; m_cnt2 = 0;
            e.hit = 1'b0; e.z_reg = 1'b0;
        end else if (run) begin
            e.hit   = (nxt == 2'd3) && (m_st != 2'd3);
            e.z_reg = ent[0];
            if (nxt != m_st) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            m_st = nxt;
        end else begin
            e.hit = 1'b0; e.z_reg = 1'b0;
        end
        e.st = m_st; e.cnt = 8'(m_cnt); e.cnt2 = 2'(m_cnt2);
        if (cfg_we && !run) m_tbl[cfg_addr] = cfg_wdata;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("rdata",  rdata0, e.rdata);
        check("rdata1", rdata1, e.rdata);
        check("err",    err0,   e.err);
        check("err1",   err1,   e.err);
        check("state",  st0,    e.st);
        check("state1", st1,    e.st);
        check("hit",    hit0,   e.hit);
        check("hit1",   hit1,   e.hit);
        check("cnt",    cnt0,   e.cnt);
        check("cnt_sat", cnt1,  e.cnt2);
        check("z_reg",  z1,     e.z_reg);
        if (hit0) hit_seen++;
    endtask

    task automatic drive(input logic r, input logic sc, input logic [1:0] xx,
                         input logic we, input logic [3:0] a, input logic [2:0] wd);
        run = r; sync_clr = sc; x = xx; cfg_we = we; cfg_addr = a; cfg_wdata = wd;
        cycle();
    endtask

    logic [1:0] s3_st [4] = '{2'd3, 2'd3, 2'd2, 2'd1};
    logic [1:0] s3_x  [4] = '{2'b11, 2'b11, 2'b00, 2'b10};
    logic       s3_z  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        reset = 1'b1; run = 1'b0; sync_clr = 1'b0; x = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        model_reset();
        #12;
        check("rst_state", st0, 0);
        check("rst_cnt", cnt0, 0);
        check("rst_hit", hit0, 0);
        check("rst_rdata", rdata0, 0);
        reset = 1'b0;

        // 1: reset table is all self-loops
        hit_seen = 0;
        repeat (4) drive(1'b1, 1'b0, 2'b11, 1'b0, 4'd0, 3'd0);
        check("s1_hit_none", hit_seen, 0);

        // 2: program and read back
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b0, 2'b00, 1'b1, 4'(i), prog_entry(i));
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 2'b00, 1'b0, 4'(i), 3'd0);
            check("s2_readback", rdata0, prog_entry(i));
        end

        // 3: A -> D,D,C,B
        hit_seen = 0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, s3_x[k], 1'b0, 4'd0, 3'd0);
            check("s3_state", st0, s3_st[k]);
            check("s3_z", z_pre, s3_z[k]);
            check("s3_zreg", z1, s3_z[k]);
        end
        check("s3_cnt", cnt0, 3);
        check("s3_hit_once", hit_seen, 1);

        // 4: write in run mode is rejected; sync_clr mid-run
        drive(1'b1, 1'b0, 2'b11, 1'b1, 4'd5, 3'b111);
        check("s4_err", err0, 1);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 4'd5, 3'd0);
        check("s4_unchanged", rdata0, 3'b000);
        drive(1'b1, 1'b1, 2'b11, 1'b0, 4'd0, 3'd0);
        check("s4_clr_state", st0, 0);
        check("s4_clr_cnt", cnt0, 0);

        // 5: toggling A<->D saturates the 2-bit counter
        for (int k = 0; k < 6; k++) drive(1'b1, 1'b0, (k % 2 == 0) ? 2'b11 : 2'b10, 1'b0, 4'd0, 3'd0);
        check("s5_cnt8", cnt0, 6);
        check("s5_cnt2_sat", cnt1, 3);

        // sync_clr together with a table write
        drive(1'b0, 1'b1, 2'b00, 1'b1, 4'd15, 3'b011);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 4'd15, 3'd0);
        check("clr_we_entry", rdata0, 3'b011);

        // 6: async reset between edges
        drive(1'b1, 1'b0, 2'b11, 1'b1, 4'd3, 3'd0);
        check("s6_pre_state", st0, 3);
        #3;
        reset = 1'b1;
        #1;
        check("s6_state", st0, 0);
        check("s6_cnt", cnt0, 0);
        check("s6_cnt1", cnt1, 0);
        check("s6_hit", hit0, 0);
        check("s6_err", err0, 0);
        check("s6_rdata", rdata0, 0);
        check("s6_zreg", z1, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, 2'b11, 1'b0, 4'd3, 3'd0);
        check("s6_tbl_revert", rdata0, 3'b000);
        drive(1'b1, 1'b0, 2'b11, 1'b0, 4'd12, 3'd0);
        check("s6_selfloop", st0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
